// File: rtl/sram_chip_responder_if.sv
// sram_chip_responder_if: control and address pins of the external 16-bit SRAM bus.
// The bidirectional data bus stays a plain inout port so tristate resolution remains at module level.
interface sram_chip_responder_if #(
    parameter int ADDR_W = 18
);
    logic [ADDR_W-1:0] addr;
    logic              ub_n;
    logic              lb_n;
    logic              we_n;
    logic              ce_n;
    logic              oe_n;
    modport master (output addr, ub_n, lb_n, we_n, ce_n, oe_n);
    modport slave  (input  addr, ub_n, lb_n, we_n, ce_n, oe_n);
endinterface

// File: rtl/sram_chip_responder.sv
// sram_chip_responder: chip-side model of a 16-bit SRAM with byte lanes, pipelined read latency,
// access counters and sticky protocol/range error flags.
module sram_chip_responder #(
    parameter int ADDR_W    = 18,
    parameter int MEM_WORDS = 65536,
    parameter int READ_LAT  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sram_chip_responder_if.slave bus,
    inout  wire  [15:0]          sram_dq,
    output logic [15:0]          rd_count,
    output logic [15:0]          wr_count,
    output logic                 proto_err,
    output logic                 range_err
);
    localparam int IW = MEM_WORDS > 1 ? $clog2(MEM_WORDS) : 1;
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(MEM_WORDS);

    typedef struct packed {
        logic          valid;
        logic          in_range;
        logic          ub_n;
        logic          lb_n;
        logic [IW-1:0] idx;
    } entry_t;

    logic [15:0] mem [MEM_WORDS];
    entry_t      pipe     [READ_LAT];
    entry_t      pipe_nxt [READ_LAT];
    entry_t      out;
    logic        wr;
    logic        rd_req;
    logic        in_range;
    logic        drive;
    logic [IW-1:0] idx;
    logic [15:0] rd_word;

    assign wr       = ~bus.ce_n & ~bus.we_n;
    assign rd_req   = ~bus.ce_n &  bus.we_n & ~bus.oe_n;
    assign in_range = {1'b0, bus.addr} < LIMIT;
    assign idx      = bus.addr[IW-1:0];
    assign out      = pipe[READ_LAT-1];

    // An entry arriving at the output on a write edge is dropped: the bus is busy writing.
    always_comb begin
        pipe_nxt[0] = {rd_req, in_range, bus.ub_n, bus.lb_n, idx};
        for (int i = 1; i < READ_LAT; i++) pipe_nxt[i] = pipe[i-1];
        pipe_nxt[READ_LAT-1].valid = pipe_nxt[READ_LAT-1].valid & ~wr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe      <= '{default: '0};
            rd_count  <= '0;
            wr_count  <= '0;
            proto_err <= 1'b0;
            range_err <= 1'b0;
        end else begin
            pipe <= pipe_nxt;
            if (pipe_nxt[READ_LAT-1].valid) rd_count <= rd_count + 16'd1;
            if (wr && !(bus.ub_n && bus.lb_n)) wr_count <= wr_count + 16'd1;
            if (wr && !bus.oe_n) proto_err <= 1'b1;
            if ((wr || rd_req) && !in_range) range_err <= 1'b1;
        end
    end

    // Array contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr && in_range) begin
            if (!bus.ub_n) mem[idx][15:8] <= sram_dq[15:8];
            if (!bus.lb_n) mem[idx][7:0]  <= sram_dq[7:0];
        end
    end

    assign rd_word = out.in_range ? mem[out.idx] : 16'h0000;
    assign drive   = out.valid & rd_req;

    assign sram_dq[15:8] = (drive && !out.ub_n) ? rd_word[15:8] : 8'hzz;
    assign sram_dq[7:0]  = (drive && !out.lb_n) ? rd_word[7:0]  : 8'hzz;
endmodule

// File: tb/tb_sram_chip_responder.sv
// tb_sram_chip_responder: randomized and directed stimulus against a request-list SRAM model;
// expected bus/counter state is queued per cycle and compared by an independent monitor.
module tb_sram_chip_responder;
    localparam int ADDR_W    = 18;
    localparam int MEM_WORDS = 4096;
    localparam int READ_LAT  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_chip_responder_if #(.ADDR_W(ADDR_W)) bus ();
    wire  [15:0] dq;
    logic        tb_oe = 1'b0;
    logic [15:0] tb_dq = 16'h0;
    logic [15:0] rd_count;
    logic [15:0] wr_count;
    logic        proto_err;
    logic        range_err;

    assign dq = tb_oe ? tb_dq : 16'hzzzz;
    // Undriven bytes float high, so a released lane reads as 8'hFF.
    for (genvar i = 0; i < 16; i++) begin : g_pu
        pullup (dq[i]);
    end

    sram_chip_responder #(.ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS), .READ_LAT(READ_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .sram_dq(dq),
        .rd_count(rd_count), .wr_count(wr_count), .proto_err(proto_err), .range_err(range_err)
    );

    typedef struct packed {
        logic ce_n, we_n, oe_n, ub_n, lb_n;
        logic [ADDR_W-1:0] addr;
        logic [15:0] data;
    } op_t;
    typedef struct packed {
        logic [15:0] dq, rd, wr;
        logic proto, range_f;
    } exp_t;
    typedef struct {
        int   edge_n;
        int   addr;
        logic ub_n, lb_n;
    } req_t;

    exp_t        sb [$];
    req_t        rq [$];
    logic [15:0] mmem [MEM_WORDS];
    int          checks = 0, errors = 0;
    int          m_rd = 0, m_wr = 0, ecount = 0;
    bit          m_proto = 0, m_range = 0, cur_valid = 0, have_pend = 0;
    req_t        cur;
    op_t         pend;
    exp_t        mon_e;

    function automatic op_t rd_op(int a, logic ub = 1'b0, logic lb = 1'b0);
        return '{1'b0, 1'b1, 1'b0, ub, lb, ADDR_W'(a), 16'h0};
    endfunction
    function automatic op_t wr_op(int a, logic [15:0] d, logic ub = 1'b0, logic lb = 1'b0);
        return '{1'b0, 1'b0, 1'b1, ub, lb, ADDR_W'(a), d};
    endfunction
    function automatic op_t idle_op();
        return '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, ADDR_W'(0), 16'h0};
    endfunction

    function automatic void chk(string name, logic [15:0] act, logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %h required %h at %0t", name, act, req, $time);
        end
    endfunction

    // Model of one sampled edge: array update, counters, flags, and which read request
    // (issued READ_LAT-1 edges earlier) now sits at the output.
    function automatic void apply(op_t p);
        bit w   = !p.ce_n && !p.we_n;
        bit r   = !p.ce_n && p.we_n && !p.oe_n;
        bit inr = p.addr < MEM_WORDS;
        int a   = int'(p.addr);
        ecount++;
        if (w && inr && !p.ub_n) mmem[a][15:8] = p.data[15:8];
        if (w && inr && !p.lb_n) mmem[a][7:0]  = p.data[7:0];
        if (w && (!p.ub_n || !p.lb_n)) m_wr++;
        if (w && !p.oe_n) m_proto = 1;
        if ((w || r) && !inr) m_range = 1;
        if (r) rq.push_back('{ecount, a, p.ub_n, p.lb_n});
        cur_valid = 0;
        while (rq.size() > 0 && rq[0].edge_n < ecount - READ_LAT + 1) void'(rq.pop_front());
        if (rq.size() > 0 && rq[0].edge_n == ecount - READ_LAT + 1) begin
            cur = rq.pop_front();
            cur_valid = !w;
            if (!w) m_rd++;
        end
    endfunction

    function automatic exp_t expect_now(op_t o);
        bit          drv  = cur_valid && !o.ce_n && o.we_n && !o.oe_n;
        logic [15:0] word = (cur.addr < MEM_WORDS) ? mmem[cur.addr] : 16'h0000;
        logic [15:0] v    = (!o.ce_n && !o.we_n) ? o.data : 16'hFFFF;
        if (drv && !cur.ub_n) v[15:8] = word[15:8];
        if (drv && !cur.lb_n) v[7:0]  = word[7:0];
        return '{v, 16'(m_rd), 16'(m_wr), m_proto, m_range};
    endfunction

    task automatic drive(op_t o);
        bus.ce_n = o.ce_n; bus.we_n = o.we_n; bus.oe_n = o.oe_n;
        bus.ub_n = o.ub_n; bus.lb_n = o.lb_n; bus.addr = o.addr;
        tb_oe = !o.ce_n && !o.we_n;
        tb_dq = o.data;
    endtask

    task automatic step(op_t o, bit c = 1'b1);
        @(posedge clk);
        if (have_pend) apply(pend);
        #1;
        drive(o);
        pend = o;
        have_pend = 1;
        if (c) sb.push_back(expect_now(o));
    endtask

    function automatic op_t rand_op();
        int k = $urandom_range(0, 9);
        int a = $urandom_range(0, 63);
        logic ub = ($urandom_range(0, 3) == 0);
        logic lb = ($urandom_range(0, 3) == 0);
        if (k <= 3) return rd_op(a, ub, lb);
        if (k <= 6) return wr_op(a, 16'($urandom), ub, lb);
        if (k == 7) return idle_op();
        if (k == 8) return '{1'b0, 1'b1, 1'b1, ub, lb, ADDR_W'(a), 16'h0};
        return ($urandom_range(0, 1) == 0) ? rd_op(MEM_WORDS + a) : wr_op(MEM_WORDS + a, 16'($urandom));
    endfunction

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("dq", dq, mon_e.dq);
            chk("rd_count", rd_count, mon_e.rd);
            chk("wr_count", wr_count, mon_e.wr);
            chk("proto_err", {15'b0, proto_err}, {15'b0, mon_e.proto});
            chk("range_err", {15'b0, range_err}, {15'b0, mon_e.range_f});
        end
    end

    initial begin
        drive(idle_op());
        repeat (3) @(posedge clk);
        #1;
        chk("reset_dq", dq, 16'hFFFF);
        chk("reset_rd_count", rd_count, 16'h0);
        chk("reset_wr_count", wr_count, 16'h0);
        chk("reset_flags", {14'b0, proto_err, range_err}, 16'h0);
        rst_n = 1'b1;
        pend = idle_op();
        have_pend = 1;
        for (int a = 0; a < 64; a++) step(wr_op(a, 16'($urandom)));
        // full-word write then read back
        step(wr_op(4, 16'hBEEF)); step(rd_op(4)); step(rd_op(0)); step(rd_op(0));
        // byte lanes
        step(wr_op(8, 16'h1234)); step(wr_op(8, 16'hAB00, 1'b0, 1'b1));
        step(rd_op(8)); step(rd_op(8, 1'b1, 1'b0)); step(rd_op(0)); step(rd_op(0)); step(idle_op());
        // back-to-back pipelined reads
        step(rd_op(1)); step(rd_op(2)); step(rd_op(3)); step(rd_op(0)); step(rd_op(0)); step(idle_op());
        // write with OE also asserted
        step('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ADDR_W'(32), 16'h5555});
        step(rd_op(32)); step(rd_op(0)); step(rd_op(0)); step(idle_op());
        // out-of-range write must not alias into the array; out-of-range read returns zero
        step(wr_op(MEM_WORDS, 16'h7777)); step(rd_op(MEM_WORDS)); step(rd_op(0)); step(rd_op(0)); step(idle_op());
        repeat (2000) step(rand_op());
        // async reset while read data is on the bus
        step(rd_op(16)); step(rd_op(16)); step(rd_op(16));
        @(negedge clk);
        #1;
        chk("pre_reset_dq", dq, mmem[16]);
        rst_n = 1'b0;
        #1;
        chk("async_reset_dq", dq, 16'hFFFF);
        chk("async_reset_rd_count", rd_count, 16'h0);
        chk("async_reset_wr_count", wr_count, 16'h0);
        chk("async_reset_flags", {14'b0, proto_err, range_err}, 16'h0);
        m_rd = 0; m_wr = 0; m_proto = 0; m_range = 0; cur_valid = 0;
        rq.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(rd_op(16)); step(rd_op(16)); step(rd_op(0)); step(idle_op());
        // 65536 accepted writes bring the write counter back to its start value
        repeat (65536) step(wr_op($urandom_range(0, 63), 16'($urandom)), 1'b0);
        step(rd_op(5)); step(rd_op(6)); step(rd_op(0)); step(idle_op()); step(idle_op());
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending %0d required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
